keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Upstream stage of the calculator datapath.
- Drives the columns of a 4x5 active-low matrix keypad and samples the rows.
- Debounces the press and converts the key position to the calculator key code.
- Emits one single-cycle `valid` strobe with `Key_input` per physical press. This is exactly the (`Key_input`, `valid`) pair the calculator consumes.

Parameters:
- `SCAN_DIV`, 1000: clocks each column stays driven before the rows are evaluated (minimum 4).
- `DEBOUNCE_CYCLES`, 50000: clocks of stable level required to accept a press or a release.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `row` in 4: keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col` out 5: keypad column drive, active-low, exactly one bit low at all times.
- `Key_input` out 5: key code of the last accepted key; held until the next accepted key.
- `valid` out 1: one-clock strobe marking a new `Key_input`.

Behaviour:
- Key codes:
  - digits 0-9 = 0-9; AC = 10; toggle = 12; / = 13; * = 14; - = 15; + = 16; = = 17.
  - Code 11 and codes above 17 are never emitted.
- Key map, position (row,col) -> code:
  - row0: 1, 2, 3, +, AC
  - row1: 4, 5, 6, -, toggle
  - row2: 7, 8, 9, *, unmapped
  - row3: 0, unmapped, =, /, unmapped
- Reset (async, immediate, mid-operation included): `col` = 5'b11110, `Key_input` = 0, `valid` = 0, state SCAN, all counters 0. No strobe is produced for a press in progress at reset.
- Row input passes through a 2-flop synchronizer; all decisions use the synchronized value `row_s`.
- All outputs are registered.
- SCAN:
  - Divider counts `SCAN_DIV` clocks; its terminal count is the tick.
  - On tick with `row_s` == 4'hF: rotate the low bit of `col` to the next column, 4 wrapping to 0.
  - On tick with any `row_s` bit low: latch column index and row index, then -> DEBOUNCE. If several rows are low, the lowest-numbered row wins. The column stays frozen.
- DEBOUNCE:
  - Counts `DEBOUNCE_CYCLES` while the latched row bit stays low.
  - Latched row bit goes high before the count completes -> SCAN: column advances, no strobe, counter cleared.
  - Count complete, mapped position -> EMIT.
  - Count complete, unmapped position -> WAIT_RELEASE with no strobe.
- EMIT (one cycle):
  - `Key_input` <= code and `valid` <= 1 on the same edge; `valid` returns to 0 on the next edge.
  - -> WAIT_RELEASE.
- WAIT_RELEASE:
  - Requires `row_s` == 4'hF for `DEBOUNCE_CYCLES` consecutive clocks; any low bit restarts the count.
  - On completion -> SCAN and advance the column.
  - Column stays frozen throughout.
  - No auto-repeat. Additional keys pressed while one is held are ignored.
- Latency, from the first clock `row` is low with the column already driven:
  - Detection at the next tick that occurs at least 2 clocks later.
  - `valid` high `DEBOUNCE_CYCLES` + 1 clocks after that tick.
- Counter widths: `$clog2` of the respective parameter. Counters saturate and never wrap inside a state.

Decomposition:
- Shared package `keypad_pkg` holds:
  - the key code constants: `KEY_AC`, `KEY_TOGGLE`, `KEY_DIV`, `KEY_MUL`, `KEY_SUB`, `KEY_ADD`, `KEY_EQ`, `KEY_NONE`;
  - the state enum: SCAN, DEBOUNCE, EMIT, WAIT_RELEASE.
- One natural sub-module, `keypad_keymap`: combinational 3-bit col + 2-bit row -> 5-bit code plus a mapped flag. The calculator bench reuses it.

Test Plan (all with `SCAN_DIV`=4, `DEBOUNCE_CYCLES`=8):
- Reset: assert `rst` mid-scan -> `col`=11110, `valid`=0, `Key_input`=0 within the same cycle, with no clock edge needed.
- Press row1 while `col`=11101, hold 60 clocks, release -> exactly one `valid` pulse with `Key_input`=5; `col` frozen at 11101 until 8 clocks after release, then 11011.
- Bounce: row0 low for 3 clocks during DEBOUNCE at col3 -> no `valid`, scanning resumes at col4 (`col`=01111).
- Hold = (row3, col2) for 300 clocks -> single pulse `Key_input`=17; pressing row0 additionally meanwhile -> no further pulse.
- Rows 0 and 2 low together at col0 -> `Key_input`=1; unmapped (row2, col4) pressed -> no `valid`, and the block still waits for release.
- Press 4 (row1, col0), release, then press + (row0, col3) -> two pulses, codes 4 then 16, in order; `Key_input` holds 16 afterwards.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad scanner and its consumers.
//   - calculator key code constants (KEY_*)
//   - scanner state enum
//   - small helpers: lowest active-low row, column rotation, column drive pattern
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 5;

    // Calculator key codes for the non-digit keys; digits 0-9 map to themselves.
    localparam logic [4:0] KEY_AC     = 5'd10;
    localparam logic [4:0] KEY_TOGGLE = 5'd12;
    localparam logic [4:0] KEY_DIV    = 5'd13;
    localparam logic [4:0] KEY_MUL    = 5'd14;
    localparam logic [4:0] KEY_SUB    = 5'd15;
    localparam logic [4:0] KEY_ADD    = 5'd16;
    localparam logic [4:0] KEY_EQ     = 5'd17;
    // Code reported for unmapped positions; never presented on Key_input.
    localparam logic [4:0] KEY_NONE   = 5'd31;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        EMIT         = 2'd2,
        WAIT_RELEASE = 2'd3
    } scan_state_t;

    // Index of the lowest-numbered row that is pulled low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] row);
        logic [1:0] idx;
        casez (row)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Next column index, wrapping 4 -> 0.
    function automatic logic [2:0] next_col(input logic [2:0] idx);
        logic [2:0] nxt;
        if (idx >= 3'd4) begin
            nxt = 3'd0;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

    // Active-low one-cold column drive for a column index.
    function automatic logic [4:0] col_drive(input logic [2:0] idx);
        logic [4:0] drv;
        case (idx)
            3'd0:    drv = 5'b11110;
            3'd1:    drv = 5'b11101;
            3'd2:    drv = 5'b11011;
            3'd3:    drv = 5'b10111;
            3'd4:    drv = 5'b01111;
            default: drv = 5'b11110;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the key-code strobe pair.
//   row       : keypad rows, active-low (keypad -> scanner)
//   col       : column drive, active-low one-cold (scanner -> keypad)
//   Key_input : last accepted key code (scanner -> calculator)
//   valid     : one-clock strobe marking a new Key_input
// master = scanner side, slave = keypad/calculator side.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [4:0] col;
    logic [4:0] Key_input;
    logic       valid;

    modport master (
        input  row,
        output col,
        output Key_input,
        output valid
    );

    modport slave (
        output row,
        input  col,
        input  Key_input,
        input  valid
    );
endinterface

// File: rtl/keypad_keymap.sv
// keypad_keymap: combinational (col, row) position -> calculator key code.
//   col_idx : column index 0..4
//   row_idx : row index 0..3
//   code    : key code, KEY_NONE for unmapped positions
//   mapped  : 1 when the position carries a key
module keypad_keymap
    import keypad_pkg::*;
(
    input  logic [2:0] col_idx,
    input  logic [1:0] row_idx,
    output logic [4:0] code,
    output logic       mapped
);

    // Position lookup; everything outside the table is unmapped.
    always_comb begin
        code   = KEY_NONE;
        mapped = 1'b1;
        case ({row_idx, col_idx})
            {2'd0, 3'd0}: code = 5'd1;
            {2'd0, 3'd1}: code = 5'd2;
            {2'd0, 3'd2}: code = 5'd3;
            {2'd0, 3'd3}: code = KEY_ADD;
            {2'd0, 3'd4}: code = KEY_AC;
            {2'd1, 3'd0}: code = 5'd4;
            {2'd1, 3'd1}: code = 5'd5;
            {2'd1, 3'd2}: code = 5'd6;
            {2'd1, 3'd3}: code = KEY_SUB;
            {2'd1, 3'd4}: code = KEY_TOGGLE;
            {2'd2, 3'd0}: code = 5'd7;
            {2'd2, 3'd1}: code = 5'd8;
            {2'd2, 3'd2}: code = 5'd9;
            {2'd2, 3'd3}: code = KEY_MUL;
            {2'd3, 3'd0}: code = 5'd0;
            {2'd3, 3'd2}: code = KEY_EQ;
            {2'd3, 3'd3}: code = KEY_DIV;
            default: begin
                code   = KEY_NONE;
                mapped = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x5 active-low matrix keypad, debounces press and
// release, and emits one (Key_input, valid) strobe per physical press.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : keypad_scanner_if.master (row in; col, Key_input, valid out)
// Parameters:
//   SCAN_DIV        : clocks per column before rows are evaluated (>= 4)
//   DEBOUNCE_CYCLES : stable clocks needed to accept a press or a release
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  bus
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DEB_W-1:0] DEB_ZERO = {DEB_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DEB_W-1:0] DEB_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};

    logic [3:0]       row_meta_r;
    logic [3:0]       row_s;
    scan_state_t      state_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [DEB_W-1:0] deb_cnt_r;
    logic [2:0]       col_idx_r;
    logic [1:0]       row_idx_r;
    logic [4:0]       col_r;
    logic [4:0]       key_r;
    logic             valid_r;

    logic [4:0]       map_code_s;
    logic             map_hit_s;
    logic             tick_s;
    logic             rows_idle_s;
    logic             latched_row_high_s;
    logic [2:0]       col_next_s;

    keypad_keymap u_keymap (
        .col_idx (col_idx_r),
        .row_idx (row_idx_r),
        .code    (map_code_s),
        .mapped  (map_hit_s)
    );

    assign tick_s             = (div_cnt_r == DIV_LAST);
    assign rows_idle_s        = (row_s == 4'hF);
    assign latched_row_high_s = row_s[row_idx_r];
    assign col_next_s         = next_col(col_idx_r);

    assign bus.col       = col_r;
    assign bus.Key_input = key_r;
    assign bus.valid     = valid_r;

    // Two-flop synchronizer for the asynchronous row lines; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_r <= 4'hF;
            row_s      <= 4'hF;
        end else begin
            row_meta_r <= bus.row;
            row_s      <= row_meta_r;
        end
    end

    // Scan / debounce / emit / release FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= SCAN;
            div_cnt_r <= DIV_ZERO;
            deb_cnt_r <= DEB_ZERO;
            col_idx_r <= 3'd0;
            row_idx_r <= 2'd0;
            col_r     <= 5'b11110;
            key_r     <= 5'd0;
            valid_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                SCAN: begin
                    if (tick_s) begin
                        div_cnt_r <= DIV_ZERO;
                        if (rows_idle_s) begin
                            col_idx_r <= col_next_s;
                            col_r     <= col_drive(col_next_s);
                        end else begin
                            // Column stays frozen on the detected key.
                            row_idx_r <= lowest_low_row(row_s);
                            deb_cnt_r <= DEB_ZERO;
                            state_r   <= DEBOUNCE;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (latched_row_high_s) begin
                        // Bounce: drop the candidate and move on.
                        deb_cnt_r <= DEB_ZERO;
                        div_cnt_r <= DIV_ZERO;
                        col_idx_r <= col_next_s;
                        col_r     <= col_drive(col_next_s);
                        state_r   <= SCAN;
                    end else if (deb_cnt_r == DEB_LAST) begin
                        deb_cnt_r <= DEB_ZERO;
                        if (map_hit_s) begin
                            state_r <= EMIT;
                        end else begin
                            state_r <= WAIT_RELEASE;
                        end
                    end else begin
                        deb_cnt_r <= deb_cnt_r + DEB_ONE;
                    end
                end
                EMIT: begin
                    key_r     <= map_code_s;
                    valid_r   <= 1'b1;
                    deb_cnt_r <= DEB_ZERO;
                    state_r   <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    // Any low row restarts the release window, so extra keys
                    // pressed meanwhile only delay the return to scanning.
                    if (!rows_idle_s) begin
                        deb_cnt_r <= DEB_ZERO;
                    end else if (deb_cnt_r == DEB_LAST) begin
                        deb_cnt_r <= DEB_ZERO;
                        div_cnt_r <= DIV_ZERO;
                        col_idx_r <= col_next_s;
                        col_r     <= col_drive(col_next_s);
                        state_r   <= SCAN;
                    end else begin
                        deb_cnt_r <= deb_cnt_r + DEB_ONE;
                    end
                end
                default: begin
                    state_r   <= SCAN;
                    div_cnt_r <= DIV_ZERO;
                    deb_cnt_r <= DEB_ZERO;
                    col_idx_r <= 3'd0;
                    col_r     <= 5'b11110;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed, table-driven bench for keypad_scanner with
// SCAN_DIV=4 and DEBOUNCE_CYCLES=8. A small keypad model pulls a row low
// whenever a pressed key sits on the currently driven column.
module tb_keypad_scanner;

    logic clk;
    logic rst;
    logic [3:0][4:0] pressed;
    logic [3:0] row_drive;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix model: a pressed key connects its row to its column.
    always_comb begin
        row_drive = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (pressed[r][c] && !kif.col[c]) row_drive[r] = 1'b0;
            end
        end
    end
    assign kif.row = row_drive;

    int n_total = 0;
    int n_pass = 0;
    int pulse_cnt = 0;
    int double_cnt = 0;
    logic prev_valid = 1'b0;
    int code_q[$];

    // Strobe monitor: counts pulses, records codes, flags multi-cycle strobes.
    always @(negedge clk) begin
        if (kif.valid) begin
            pulse_cnt = pulse_cnt + 1;
            code_q.push_back(int'(kif.Key_input));
            if (prev_valid) double_cnt = double_cnt + 1;
        end
        prev_valid = kif.valid;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bounded wait until the given column pattern is driven (seen at negedge).
    task automatic wait_col(input logic [4:0] target);
        int found;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (kif.col == target) begin
                found = 1;
                break;
            end
        end
        check("wait_col", found, 1);
    endtask

    task automatic press_key(input int r, input int c, input int hold, output int pulses);
        int base;
        base = pulse_cnt;
        pressed[r][c] = 1'b1;
        repeat (hold) @(negedge clk);
        pressed[r][c] = 1'b0;
        repeat (30) @(negedge clk);
        pulses = pulse_cnt - base;
    endtask

    typedef struct {
        int r;
        int c;
        int mapped;
        int code;
    } vec_t;

    vec_t vecs[20];

    initial begin
        int base;
        int pulses;
        int lat;
        int held_key;

        vecs[0]  = '{0, 0, 1, 1};   vecs[1]  = '{0, 1, 1, 2};
        vecs[2]  = '{0, 2, 1, 3};   vecs[3]  = '{0, 3, 1, 16};
        vecs[4]  = '{0, 4, 1, 10};  vecs[5]  = '{1, 0, 1, 4};
        vecs[6]  = '{1, 1, 1, 5};   vecs[7]  = '{1, 2, 1, 6};
        vecs[8]  = '{1, 3, 1, 15};  vecs[9]  = '{1, 4, 1, 12};
        vecs[10] = '{2, 0, 1, 7};   vecs[11] = '{2, 1, 1, 8};
        vecs[12] = '{2, 2, 1, 9};   vecs[13] = '{2, 3, 1, 14};
        vecs[14] = '{2, 4, 0, 0};   vecs[15] = '{3, 0, 1, 0};
        vecs[16] = '{3, 1, 0, 0};   vecs[17] = '{3, 2, 1, 17};
        vecs[18] = '{3, 3, 1, 13};  vecs[19] = '{3, 4, 0, 0};

        pressed = '0;
        rst = 1'b1;
        #3;
        check("reset_col", int'(kif.col), int'(5'b11110));
        check("reset_valid", int'(kif.valid), 0);
        check("reset_key", int'(kif.Key_input), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Key 5 at col1: latency, single pulse, column frozen until release.
        wait_col(5'b11110);
        wait_col(5'b11101);
        base = pulse_cnt;
        pressed[1][1] = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (kif.valid) begin
                lat = i;
                break;
            end
        end
        check("press_latency", lat, 13);
        check("press5_key", int'(kif.Key_input), 5);
        repeat (47) @(negedge clk);
        check("press5_frozen", int'(kif.col), int'(5'b11101));
        pressed[1][1] = 1'b0;
        repeat (9) @(negedge clk);
        check("release_still_frozen", int'(kif.col), int'(5'b11101));
        @(negedge clk);
        check("release_advance", int'(kif.col), int'(5'b11011));
        check("press5_pulses", pulse_cnt - base, 1);

        // Bounce during DEBOUNCE at col3: no strobe, scanning resumes at col4.
        wait_col(5'b10111);
        base = pulse_cnt;
        pressed[0][3] = 1'b1;
        repeat (6) @(negedge clk);
        pressed[0][3] = 1'b0;
        repeat (2) @(negedge clk);
        check("bounce_not_yet", int'(kif.col), int'(5'b10111));
        @(negedge clk);
        check("bounce_resume", int'(kif.col), int'(5'b01111));
        repeat (30) @(negedge clk);
        check("bounce_pulses", pulse_cnt - base, 0);

        // Long hold of '=' plus a second key on the same column.
        wait_col(5'b11101);
        wait_col(5'b11011);
        base = pulse_cnt;
        pressed[3][2] = 1'b1;
        repeat (20) @(negedge clk);
        pressed[0][2] = 1'b1;
        repeat (280) @(negedge clk);
        check("hold_frozen", int'(kif.col), int'(5'b11011));
        pressed[3][2] = 1'b0;
        pressed[0][2] = 1'b0;
        repeat (30) @(negedge clk);
        check("hold_pulses", pulse_cnt - base, 1);
        check("hold_key", int'(kif.Key_input), 17);

        // Rows 0 and 2 together at col0: lowest row wins.
        wait_col(5'b01111);
        wait_col(5'b11110);
        base = pulse_cnt;
        pressed[0][0] = 1'b1;
        pressed[2][0] = 1'b1;
        repeat (40) @(negedge clk);
        pressed[0][0] = 1'b0;
        pressed[2][0] = 1'b0;
        repeat (30) @(negedge clk);
        check("multirow_pulses", pulse_cnt - base, 1);
        check("multirow_key", int'(kif.Key_input), 1);

        // Unmapped (row2, col4): no strobe, but release is still awaited.
        wait_col(5'b10111);
        wait_col(5'b01111);
        base = pulse_cnt;
        pressed[2][4] = 1'b1;
        repeat (100) @(negedge clk);
        check("unmapped_frozen", int'(kif.col), int'(5'b01111));
        pressed[2][4] = 1'b0;
        repeat (11) @(negedge clk);
        check("unmapped_release", int'(kif.col), int'(5'b11110));
        check("unmapped_pulses", pulse_cnt - base, 0);
        check("unmapped_key_held", int'(kif.Key_input), 1);

        // Two keys in sequence: 4 then +.
        base = pulse_cnt;
        press_key(1, 0, 60, pulses);
        press_key(0, 3, 60, pulses);
        check("seq_pulses", pulse_cnt - base, 2);
        if (code_q.size() >= 2) begin
            check("seq_first", code_q[code_q.size()-2], 4);
            check("seq_second", code_q[code_q.size()-1], 16);
        end else begin
            check("seq_codes_recorded", code_q.size(), 2);
        end
        repeat (20) @(negedge clk);
        check("seq_key_held", int'(kif.Key_input), 16);

        // Full key map sweep.
        held_key = 16;
        for (int i = 0; i < 20; i++) begin
            press_key(vecs[i].r, vecs[i].c, 60, pulses);
            if (vecs[i].mapped != 0) held_key = vecs[i].code;
            check($sformatf("map_pulses_r%0d_c%0d", vecs[i].r, vecs[i].c), pulses, vecs[i].mapped);
            check($sformatf("map_key_r%0d_c%0d", vecs[i].r, vecs[i].c), int'(kif.Key_input), held_key);
        end

        // Asynchronous reset mid-debounce: immediate, and no strobe afterwards.
        wait_col(5'b11011);
        wait_col(5'b10111);
        base = pulse_cnt;
        pressed[0][3] = 1'b1;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_col", int'(kif.col), int'(5'b11110));
        check("midrst_valid", int'(kif.valid), 0);
        check("midrst_key", int'(kif.Key_input), 0);
        pressed[0][3] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_pulses", pulse_cnt - base, 0);
        check("midrst_key_after", int'(kif.Key_input), 0);

        check("single_cycle_valid", double_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
